// File: rtl/z80_bus_responder_pkg.sv
// Shared types for the Z80 bus responder: FSM states,
// access-kind codes and the data pattern seen on idle/timeout reads.
package z80_bus_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEMW,
    ST_IOW,
    ST_ACK
  } bus_state_t;

  typedef enum logic [1:0] {
    KIND_MEM_RD,
    KIND_MEM_WR,
    KIND_IO_RD,
    KIND_IO_WR
  } acc_kind_t;

  localparam logic [7:0] IDLE_DATA = 8'hFF;

  function automatic acc_kind_t acc_kind(
    input logic mem,
    input logic wr
  );
    acc_kind_t k;
    unique case (1'b1)
      mem && !wr:  k = KIND_MEM_RD;
      mem && wr:   k = KIND_MEM_WR;
      !mem && !wr: k = KIND_IO_RD;
      default:     k = KIND_IO_WR;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/z80_bus_responder_wait_counter.sv
// bus_wait_counter: 8-bit saturating stall counter.
// Ports: load/load_val restart, en counts, term/tmo compare flags.
module bus_wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  input  logic [7:0] term_val,
  input  logic [7:0] tmo_val,
  output logic       term,
  output logic       tmo
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign term = cnt >= term_val;
  assign tmo  = cnt >= tmo_val;

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 bus target: stalls the core with WAIT_B and forwards each
// access to a 1-cycle sync SRAM port or an 8-bit handshaked I/O port.
module z80_bus_responder
  import z80_bus_responder_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int IO_WAIT  = 2,
  parameter int IO_TMO   = 64
) (
  input  logic        CLK,
  input  logic        RESET_B,
  input  logic        MREQ_B,
  input  logic        IORQ_B,
  input  logic        RD_B,
  input  logic        WR_B,
  input  logic [15:0] ADDR,
  input  logic [7:0]  BUS_WDATA,
  output logic [7:0]  BUS_RDATA,
  output logic        WAIT_B,
  output logic [15:0] MEM_ADDR,
  output logic [7:0]  MEM_WDATA,
  output logic        MEM_RE,
  output logic        MEM_WE,
  input  logic [7:0]  MEM_RDATA,
  output logic [7:0]  IO_ADDR,
  output logic [7:0]  IO_WDATA,
  output logic        IO_RD,
  output logic        IO_WR,
  input  logic        IO_READY,
  input  logic [7:0]  IO_RDATA,
  output logic        BUS_ERR
);

  localparam logic [7:0] MEM_TERM = 8'(MEM_WAIT);
  localparam logic [7:0] IO_TERM  = 8'(IO_WAIT);
  // Timeout fires on the IO_TMO-th cycle spent in IOW.
  localparam logic [7:0] TMO_CNT  = 8'(IO_TMO - 1);

  bus_state_t state;
  acc_kind_t  kind;

  logic mreq, iorq, rd, wr;
  logic req, illegal;
  logic cnt_term, cnt_tmo;
  logic [7:0] term_val;

  assign mreq = ~MREQ_B;
  assign iorq = ~IORQ_B;
  assign rd   = ~RD_B;
  assign wr   = ~WR_B;

  assign req     = (mreq ^ iorq) & (rd ^ wr);
  assign illegal = (mreq & iorq) | (rd & wr);

  assign WAIT_B = ~(req & (state != ST_ACK));

  assign term_val = (state == ST_IOW) ? IO_TERM : MEM_TERM;

  bus_wait_counter u_wait_cnt (
    .clk      (CLK),
    .rst_n    (RESET_B),
    .load     (state == ST_IDLE),
    .load_val (8'd0),
    .en       ((state == ST_MEMW) || (state == ST_IOW)),
    .term_val (term_val),
    .tmo_val  (TMO_CNT),
    .term     (cnt_term),
    .tmo      (cnt_tmo)
  );

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state     <= ST_IDLE;
      kind      <= KIND_MEM_RD;
      BUS_RDATA <= IDLE_DATA;
      MEM_ADDR  <= 16'd0;
      MEM_WDATA <= 8'd0;
      MEM_RE    <= 1'b0;
      MEM_WE    <= 1'b0;
      IO_ADDR   <= 8'd0;
      IO_WDATA  <= 8'd0;
      IO_RD     <= 1'b0;
      IO_WR     <= 1'b0;
      BUS_ERR   <= 1'b0;
    end else begin
      MEM_RE <= 1'b0;
      MEM_WE <= 1'b0;
      if (illegal) begin
        BUS_ERR <= 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            kind <= acc_kind(mreq, wr);
            if (mreq) begin
              MEM_ADDR  <= ADDR;
              MEM_WDATA <= BUS_WDATA;
              MEM_RE    <= rd;
              MEM_WE    <= wr;
              state     <= ST_MEMW;
            end else begin
              IO_ADDR  <= ADDR[7:0];
              IO_WDATA <= BUS_WDATA;
              IO_RD    <= rd;
              IO_WR    <= wr;
              state    <= ST_IOW;
            end
          end
        end
        ST_MEMW: begin
          if (cnt_term) begin
            if (kind == KIND_MEM_RD) begin
              BUS_RDATA <= MEM_RDATA;
            end
            state <= ST_ACK;
          end
        end
        ST_IOW: begin
          // A ready peripheral wins over a same-cycle timeout.
          if (cnt_term && IO_READY) begin
            if (kind == KIND_IO_RD) begin
              BUS_RDATA <= IO_RDATA;
            end
            IO_RD <= 1'b0;
            IO_WR <= 1'b0;
            state <= ST_ACK;
          end else if (cnt_tmo) begin
            BUS_RDATA <= IDLE_DATA;
            BUS_ERR   <= 1'b1;
            IO_RD     <= 1'b0;
            IO_WR     <= 1'b0;
            state     <= ST_ACK;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Randomised bench for z80_bus_responder against a
// transaction-level model with SRAM and peripheral stand-ins.
module tb_z80_bus_responder;

  localparam int MEM_WAIT = 1;
  localparam int IO_WAIT  = 2;
  localparam int IO_TMO   = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mreq_b, iorq_b, rd_b, wr_b;
  logic [15:0] addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        wait_b;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_re, mem_we;
  logic [7:0]  mem_rdata;
  logic [7:0]  io_addr, io_wdata;
  logic        io_rd, io_wr;
  logic        io_ready;
  logic [7:0]  io_rdata;
  logic        bus_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_ack = 0;

  logic [7:0] exp_rd;
  logic       exp_err;
  logic [7:0] ref_mem [logic [15:0]];

  logic [7:0] sram   [0:65535];
  bit         sram_v [0:65535];

  z80_bus_responder #(
    .MEM_WAIT (MEM_WAIT),
    .IO_WAIT  (IO_WAIT),
    .IO_TMO   (IO_TMO)
  ) dut (
    .CLK       (clk),
    .RESET_B   (rst_n),
    .MREQ_B    (mreq_b),
    .IORQ_B    (iorq_b),
    .RD_B      (rd_b),
    .WR_B      (wr_b),
    .ADDR      (addr),
    .BUS_WDATA (bus_wdata),
    .BUS_RDATA (bus_rdata),
    .WAIT_B    (wait_b),
    .MEM_ADDR  (mem_addr),
    .MEM_WDATA (mem_wdata),
    .MEM_RE    (mem_re),
    .MEM_WE    (mem_we),
    .MEM_RDATA (mem_rdata),
    .IO_ADDR   (io_addr),
    .IO_WDATA  (io_wdata),
    .IO_RD     (io_rd),
    .IO_WR     (io_wr),
    .IO_READY  (io_ready),
    .IO_RDATA  (io_rdata),
    .BUS_ERR   (bus_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] fill(input logic [15:0] a);
    if (a == 16'h1234) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Board SRAM: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_re) begin
      mem_rdata <= sram_v[mem_addr] ? sram[mem_addr] : fill(mem_addr);
    end
    if (mem_we) begin
      sram[mem_addr]   <= mem_wdata;
      sram_v[mem_addr] <= 1'b1;
    end
  end

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return fill(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic rst_chk(input string t);
    chk({t, "_wait"}, 32'(wait_b), 32'd1);
    chk({t, "_rdata"}, 32'(bus_rdata), 32'hFF);
    chk({t, "_mem"}, 32'({mem_re, mem_we, mem_addr, mem_wdata}), 32'd0);
    chk({t, "_io"}, 32'({io_rd, io_wr, io_addr, io_wdata}), 32'd0);
    chk({t, "_err"}, 32'(bus_err), 32'd0);
  endtask

  task automatic idle(input int n);
    mreq_b = 1'b1; iorq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // One access; entered and left 1 time unit after a rising edge.
  task automatic do_access(input bit io, input bit wr,
                           input logic [15:0] a, input logic [7:0] wd,
                           input int rdy_at);
    int n, ack, re_cnt, we_cnt, pulse_at, ird_cnt, iwr_cnt;
    int done, exp_ack;
    logic [15:0] m_addr;
    logic [7:0]  m_wd, i_addr, i_wd, got_rd, io_d;
    logic        got_err;
    n = 0; ack = -1; re_cnt = 0; we_cnt = 0; pulse_at = -1;
    ird_cnt = 0; iwr_cnt = 0;
    m_addr = '0; m_wd = '0; i_addr = '0; i_wd = '0;
    got_rd = 'x; got_err = 'x;
    io_d = 8'($urandom);
    mreq_b = io; iorq_b = !io; rd_b = wr; wr_b = !wr;
    addr = a; bus_wdata = wd; io_rdata = io_d; io_ready = 1'b0;
    while (ack < 0 && n < 200) begin
      @(negedge clk);
      if (mem_re) begin re_cnt++; pulse_at = n; m_addr = mem_addr; end
      if (mem_we) begin
        we_cnt++; pulse_at = n; m_addr = mem_addr; m_wd = mem_wdata;
      end
      if (io_rd) ird_cnt++;
      if (io_wr) iwr_cnt++;
      if (io_rd || io_wr) begin i_addr = io_addr; i_wd = io_wdata; end
      if (wait_b) begin
        ack = n; got_rd = bus_rdata; got_err = bus_err; last_ack = cyc;
      end
      @(posedge clk); #1;
      n++;
      if (ack < 0) begin
        addr = 16'($urandom);
        bus_wdata = 8'($urandom);
      end
      io_ready = io && (n >= rdy_at);
    end
    io_ready = 1'b0;
    if (!io) begin
      exp_ack = 2 + MEM_WAIT;
      if (wr) ref_mem[a] = wd;
      else exp_rd = ref_rd(a);
      chk("mem_ack", 32'(ack), 32'(exp_ack));
      chk("mem_re_n", 32'(re_cnt), wr ? 32'd0 : 32'd1);
      chk("mem_we_n", 32'(we_cnt), wr ? 32'd1 : 32'd0);
      chk("mem_pulse_at", 32'(pulse_at), 32'd1);
      chk("mem_addr", 32'(m_addr), 32'(a));
      if (wr) chk("mem_wdata", 32'(m_wd), 32'(wd));
      chk("mem_no_io", 32'(ird_cnt + iwr_cnt), 32'd0);
    end else begin
      done = (rdy_at > IO_WAIT + 1) ? rdy_at : IO_WAIT + 1;
      if (done > IO_TMO) begin
        done = IO_TMO;
        exp_rd = 8'hFF;
        exp_err = 1'b1;
      end else if (!wr) begin
        exp_rd = io_d;
      end
      exp_ack = done + 1;
      chk("io_ack", 32'(ack), 32'(exp_ack));
      chk("io_rd_n", 32'(ird_cnt), wr ? 32'd0 : 32'(done));
      chk("io_wr_n", 32'(iwr_cnt), wr ? 32'(done) : 32'd0);
      chk("io_addr", 32'(i_addr), 32'(a[7:0]));
      if (wr) chk("io_wdata", 32'(i_wd), 32'(wd));
      chk("io_no_mem", 32'(re_cnt + we_cnt), 32'd0);
    end
    chk("rdata", 32'(got_rd), 32'(exp_rd));
    chk("err", 32'(got_err), 32'(exp_err));
  endtask

  initial begin
    int pulses, act, wlow, first;
    rst_n = 1'b0;
    mreq_b = 1'b1; iorq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1;
    addr = '0; bus_wdata = '0; io_ready = 1'b0; io_rdata = '0;
    exp_rd = 8'hFF; exp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_chk("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_access(1'b0, 1'b0, 16'h1234, 8'h00, 0);
    chk("a5_read", 32'(exp_rd), 32'hA5);
    do_access(1'b0, 1'b1, 16'h8000, 8'h3C, 0);
    do_access(1'b1, 1'b0, 16'h77BE, 8'h00, 1);
    idle(2);
    do_access(1'b0, 1'b0, 16'h0000, 8'h00, 0);
    first = last_ack;
    do_access(1'b0, 1'b0, 16'h0001, 8'h00, 0);
    chk("b2b_gap", 32'(last_ack - first), 32'(3 + MEM_WAIT));
    do_access(1'b0, 1'b0, 16'h8000, 8'h00, 0);

    for (int i = 0; i < 40; i++) begin
      int g;
      do_access(1'($urandom), 1'($urandom), 16'($urandom % 64),
                8'($urandom), int'($urandom_range(1, 10)));
      g = int'($urandom % 3);
      if (g != 0) idle(g);
    end

    // Strobes dropped one cycle into a memory read.
    idle(1);
    mreq_b = 1'b0; rd_b = 1'b0; addr = 16'h00F0;
    exp_rd = ref_rd(16'h00F0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_re) pulses++;
      @(posedge clk); #1;
      if (i == 0) begin mreq_b = 1'b1; rd_b = 1'b1; end
    end
    chk("wd_pulses", 32'(pulses), 32'd1);
    chk("wd_rdata", 32'(bus_rdata), 32'(exp_rd));
    do_access(1'b0, 1'b0, 16'h00F1, 8'h00, 0);

    do_access(1'b1, 1'b1, 16'h0042, 8'h77, 1000);
    do_access(1'b0, 1'b0, 16'h0003, 8'h00, 0);

    // Reset while the SRAM access is in flight.
    mreq_b = 1'b0; rd_b = 1'b0; addr = 16'h2222;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pre_re", 32'(mem_re), 32'd1);
    rst_n = 1'b0;
    mreq_b = 1'b1; rd_b = 1'b1;
    #1;
    rst_chk("rst_memw");
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_rd = 8'hFF; exp_err = 1'b0;
    idle(1);

    // Both request lines low: rejected outright.
    mreq_b = 1'b0; iorq_b = 1'b0; rd_b = 1'b0; wr_b = 1'b1;
    act = 0; wlow = 0;
    repeat (3) begin
      @(negedge clk);
      if (!wait_b) wlow++;
      if (mem_re || mem_we || io_rd || io_wr) act++;
      @(posedge clk); #1;
    end
    chk("ill_wait_low", 32'(wlow), 32'd0);
    chk("ill_activity", 32'(act), 32'd0);
    @(negedge clk);
    chk("ill_err", 32'(bus_err), 32'd1);
    exp_err = 1'b1;
    @(posedge clk); #1;
    idle(1);
    do_access(1'b0, 1'b0, 16'h0005, 8'h00, 0);
    do_access(1'b1, 1'b0, 16'h0010, 8'h00, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
